// File: rtl/execute_unit.sv
// execute_unit: registered execute stage with integer ALU, RV64 word ops and an iterative multiply/divide FSM
module execute_unit #(
   parameter int XLEN   = 64,
   parameter int DSTW   = 5,
   parameter bit MDU_EN = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [3:0]      in_op,
   input  logic            in_word,
   input  logic [XLEN-1:0] in_srca,
   input  logic [XLEN-1:0] in_srcb,
   input  logic [DSTW-1:0] in_dst,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_result,
   output logic [DSTW-1:0] out_dst,
   output logic            busy
);
   localparam int SW = $clog2(XLEN);
   localparam logic [XLEN-1:0] LO = XLEN'(64'hFFFF_FFFF);
   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
   state_t r_state, w_state_n;
   logic [XLEN-1:0] r_x, r_y, r_acc, r_pc;
   logic [DSTW-1:0] r_dst;
   logic [SW-1:0]   r_cnt;
   logic            r_word, r_rem, r_negq, r_negr;
   logic            w_accept, w_mdu, w_last, w_done, w_ge, w_sgn;
   logic [31:0]     w_a32, w_b32, w_alw;
   logic [XLEN-1:0] w_alu, w_alu_res, w_ae, w_be, w_ma, w_mb;
   logic [XLEN-1:0] w_mul_acc, w_rd, w_q, w_qr, w_raw, w_mdu_res;
   logic [XLEN:0]   w_rs;

   function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   assign busy      = r_state != IDLE;
   assign in_ready  = !reset && !busy && (!out_valid || out_ready) && !flush;
   assign w_accept  = in_valid && in_ready;
   assign w_mdu     = MDU_EN && in_op >= 4'd10 && in_op <= 4'd14;
   assign w_last    = r_cnt == (r_word ? SW'(31) : SW'(XLEN-1));
   assign w_done    = busy && w_last && !flush;
   assign w_a32     = in_srca[31:0];
   assign w_b32     = in_srcb[31:0];

   always_comb begin
      w_alu = '0;
      w_alw = '0;
      case (in_op)
         4'd0: begin w_alu = in_srca + in_srcb; w_alw = w_a32 + w_b32; end
         4'd1: begin w_alu = in_srca - in_srcb; w_alw = w_a32 - w_b32; end
         4'd2: begin w_alu = in_srca & in_srcb; w_alw = w_a32 & w_b32; end
         4'd3: begin w_alu = in_srca | in_srcb; w_alw = w_a32 | w_b32; end
         4'd4: begin w_alu = in_srca ^ in_srcb; w_alw = w_a32 ^ w_b32; end
         4'd5: begin w_alu = in_srca << in_srcb[SW-1:0]; w_alw = w_a32 << w_b32[4:0]; end
         4'd6: begin w_alu = in_srca >> in_srcb[SW-1:0]; w_alw = w_a32 >> w_b32[4:0]; end
         4'd7: begin w_alu = $signed(in_srca) >>> in_srcb[SW-1:0]; w_alw = $signed(w_a32) >>> w_b32[4:0]; end
         4'd8: begin w_alu = XLEN'($signed(in_srca) < $signed(in_srcb)); w_alw = 32'($signed(w_a32) < $signed(w_b32)); end
         4'd9: begin w_alu = XLEN'(in_srca < in_srcb); w_alw = 32'(w_a32 < w_b32); end
         default: ;
      endcase
   end

   assign w_alu_res = in_word ? sx(w_alw) : w_alu;

   // Divider works on magnitudes; word operands are sign-extended first, then masked to 32 bits
   assign w_sgn = in_op == 4'd11 || in_op == 4'd13;
   assign w_ae  = in_word ? sx(w_a32) : in_srca;
   assign w_be  = in_word ? sx(w_b32) : in_srcb;
   assign w_ma  = ((w_sgn && w_ae[XLEN-1]) ? -w_ae : w_ae) & (in_word ? LO : '1);
   assign w_mb  = ((w_sgn && w_be[XLEN-1]) ? -w_be : w_be) & (in_word ? LO : '1);

   assign w_mul_acc = r_acc + (r_y[0] ? r_x : '0);
   assign w_rs      = {r_acc, r_y[XLEN-1]};
   assign w_ge      = w_rs >= {1'b0, r_x};
   assign w_rd      = w_ge ? w_rs[XLEN-1:0] - r_x : w_rs[XLEN-1:0];
   assign w_q       = {r_y[XLEN-2:0], w_ge};
   assign w_qr      = r_rem ? (r_negr ? -w_rd : w_rd) : (r_negq ? -w_q : w_q);
   assign w_raw     = (r_state == MUL) ? w_mul_acc : w_qr;
   assign w_mdu_res = r_word ? sx(w_raw[31:0]) : w_raw;

   always_comb begin
      w_state_n = r_state;
      if (flush)
         w_state_n = IDLE;
      else if (r_state == IDLE)
         w_state_n = (w_accept && w_mdu) ? ((in_op == 4'd10) ? MUL : DIV) : IDLE;
      else if (w_last)
         w_state_n = IDLE;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_state_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid  <= 1'b0;
         out_pc     <= '0;
         out_result <= '0;
         out_dst    <= '0;
         r_x        <= '0;
         r_y        <= '0;
         r_acc      <= '0;
         r_pc       <= '0;
         r_dst      <= '0;
         r_cnt      <= '0;
         r_word     <= 1'b0;
         r_rem      <= 1'b0;
         r_negq     <= 1'b0;
         r_negr     <= 1'b0;
      end else begin
         if (flush)
            out_valid <= 1'b0;
         else if (w_accept && !w_mdu) begin
            out_valid  <= 1'b1;
            out_pc     <= in_pc;
            out_result <= w_alu_res;
            out_dst    <= in_dst;
         end else if (w_done) begin
            out_valid  <= 1'b1;
            out_pc     <= r_pc;
            out_result <= w_mdu_res;
            out_dst    <= r_dst;
         end else if (out_ready)
            out_valid <= 1'b0;
         if (w_accept && w_mdu) begin
            // Word divides pre-shift the dividend so its bit 31 leaves the top first
            r_x    <= (in_op == 4'd10) ? in_srca : w_mb;
            r_y    <= (in_op == 4'd10) ? in_srcb : (in_word ? w_ma << (XLEN-32) : w_ma);
            r_acc  <= '0;
            r_cnt  <= '0;
            r_pc   <= in_pc;
            r_dst  <= in_dst;
            r_word <= in_word;
            r_rem  <= in_op >= 4'd13;
            r_negq <= w_sgn && (w_ae[XLEN-1] ^ w_be[XLEN-1]) && |w_mb;
            r_negr <= w_sgn && w_ae[XLEN-1];
         end else if (busy) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_state == MUL) begin
               r_acc <= w_mul_acc;
               r_x   <= r_x << 1;
               r_y   <= r_y >> 1;
            end else begin
               r_acc <= w_rd;
               r_y   <= w_q;
            end
         end
      end
   end
endmodule

// File: tb/tb_execute_unit.sv
// tb_execute_unit: directed vectors checked every cycle against an arithmetic reference model
module tb_execute_unit;
   logic        clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, in_word = 1'b0, out_ready = 1'b1;
   logic [63:0] in_pc = '0, in_srca = '0, in_srcb = '0;
   logic [3:0]  in_op = '0;
   logic [4:0]  in_dst = '0;
   logic        in_ready, out_valid, busy;
   logic [63:0] out_pc, out_result;
   logic [4:0]  out_dst;
   int          n_chk = 0, n_fail = 0, n_cons = 0;

   bit          m_valid = 1'b0;
   int          m_left = 0;
   logic [63:0] m_pc = '0, m_res = '0, m_ppc = '0, m_pres = '0;
   logic [4:0]  m_dst = '0, m_pdst = '0;

   typedef struct {logic [3:0] op; logic w; logic [63:0] a; logic [63:0] b;} vec_t;
   vec_t tv [24] = '{
      '{4'd1, 1'b0, 64'd10, 64'd3},
      '{4'd2, 1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0FF0},
      '{4'd3, 1'b0, 64'hF0F0_0000_0000_000F, 64'h0000_0000_1234_0000},
      '{4'd4, 1'b0, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F},
      '{4'd5, 1'b0, 64'd1, 64'd63},
      '{4'd6, 1'b0, 64'h8000_0000_0000_0000, 64'd63},
      '{4'd7, 1'b0, 64'h8000_0000_0000_0000, 64'd63},
      '{4'd8, 1'b0, -64'd1, 64'd1},
      '{4'd9, 1'b0, -64'd1, 64'd1},
      '{4'd15, 1'b0, 64'd5, 64'd5},
      '{4'd5, 1'b1, 64'd1, 64'd31},
      '{4'd6, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd1},
      '{4'd7, 1'b1, 64'h8000_0000, 64'd4},
      '{4'd1, 1'b1, 64'd0, 64'd1},
      '{4'd8, 1'b1, 64'h8000_0000, 64'd0},
      '{4'd10, 1'b0, 64'h1_2345_6789, 64'hF_EDCB_A987},
      '{4'd10, 1'b1, 64'h7FFF_FFFF, 64'h7FFF_FFFF},
      '{4'd12, 1'b0, -64'd1, 64'd3},
      '{4'd14, 1'b0, -64'd1, 64'd10},
      '{4'd11, 1'b1, 64'h8000_0000, -64'd1},
      '{4'd13, 1'b1, -64'd7, 64'd2},
      '{4'd12, 1'b1, 64'd5, 64'd0},
      '{4'd13, 1'b0, 64'd7, -64'd2},
      '{4'd11, 1'b0, -64'd100, -64'd7}
   };

   always #5 clk = ~clk;

   execute_unit #(.XLEN(64), .DSTW(5), .MDU_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_op(in_op), .in_word(in_word), .in_srca(in_srca), .in_srcb(in_srcb),
      .in_dst(in_dst), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_result(out_result), .out_dst(out_dst), .busy(busy)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] model(input logic [3:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
      logic [31:0] x, y, r;
      int sxa, sxb;
      longint la, lb;
      logic [63:0] q;
      x = a[31:0]; y = b[31:0]; sxa = x; sxb = y; la = a; lb = b;
      r = '0; q = '0;
      if (w) begin
         case (op)
            4'd0: r = x + y;
            4'd1: r = x - y;
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            4'd5: r = x << y[4:0];
            4'd6: r = x >> y[4:0];
            4'd7: r = sxa >>> y[4:0];
            4'd8: r = (sxa < sxb) ? 32'd1 : 32'd0;
            4'd9: r = (x < y) ? 32'd1 : 32'd0;
            4'd10: r = x * y;
            4'd11: if (y == 0) r = '1; else if (x == 32'h8000_0000 && y == '1) r = x; else r = sxa / sxb;
            4'd12: if (y == 0) r = '1; else r = x / y;
            4'd13: if (y == 0) r = x; else if (x == 32'h8000_0000 && y == '1) r = '0; else r = sxa % sxb;
            4'd14: if (y == 0) r = x; else r = x % y;
            default: r = '0;
         endcase
         return {{32{r[31]}}, r};
      end
      case (op)
         4'd0: q = a + b;
         4'd1: q = a - b;
         4'd2: q = a & b;
         4'd3: q = a | b;
         4'd4: q = a ^ b;
         4'd5: q = a << b[5:0];
         4'd6: q = a >> b[5:0];
         4'd7: q = la >>> b[5:0];
         4'd8: q = (la < lb) ? 64'd1 : 64'd0;
         4'd9: q = (a < b) ? 64'd1 : 64'd0;
         4'd10: q = a * b;
         4'd11: if (b == 0) q = '1; else if (a == 64'h8000_0000_0000_0000 && b == '1) q = a; else q = la / lb;
         4'd12: if (b == 0) q = '1; else q = a / b;
         4'd13: if (b == 0) q = a; else if (a == 64'h8000_0000_0000_0000 && b == '1) q = '0; else q = la % lb;
         4'd14: if (b == 0) q = a; else q = a % b;
         default: q = '0;
      endcase
      return q;
   endfunction

   // Reference timing: ALU results appear one edge after accept, MDU results N edges later
   always @(posedge clk or posedge reset) begin
      bit acc, mdu, done;
      if (reset) begin
         m_valid = 1'b0; m_left = 0; m_pc = '0; m_res = '0; m_dst = '0;
      end else begin
         acc = in_valid && !flush && m_left == 0 && (!m_valid || out_ready);
         mdu = in_op >= 4'd10 && in_op <= 4'd14;
         if (flush) begin
            m_valid = 1'b0; m_left = 0;
         end else begin
            done = m_left == 1;
            if (m_left > 0) m_left--;
            if (acc && !mdu) begin
               m_valid = 1'b1; m_res = model(in_op, in_word, in_srca, in_srcb); m_pc = in_pc; m_dst = in_dst;
            end else if (done) begin
               m_valid = 1'b1; m_res = m_pres; m_pc = m_ppc; m_dst = m_pdst;
            end else if (out_ready)
               m_valid = 1'b0;
            if (acc && mdu) begin
               m_left = in_word ? 32 : 64;
               m_pres = model(in_op, in_word, in_srca, in_srcb); m_ppc = in_pc; m_pdst = in_dst;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("in_ready", in_ready, !reset && !flush && m_left == 0 && (!m_valid || out_ready));
      chk("busy", busy, m_left > 0);
      chk("out_valid", out_valid, m_valid);
      if (m_valid) begin
         chk("out_pc", out_pc, m_pc);
         chk("out_result", out_result, m_res);
         chk("out_dst", out_dst, m_dst);
      end
      if (out_valid && out_ready) n_cons++;
   end

   task automatic send(input logic [3:0] op, input logic w, input logic [63:0] a, input logic [63:0] b, input logic [4:0] d, input logic [63:0] pc);
      bit ok = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b1; in_op = op; in_word = w; in_srca = a; in_srcb = b; in_dst = d; in_pc = pc;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_op = 4'($urandom); in_word = 1'($urandom);
      in_srca = {$urandom, $urandom}; in_srcb = {$urandom, $urandom}; in_dst = 5'($urandom); in_pc = {$urandom, $urandom};
      if (!ok) chk("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic lit(input string nm, input logic [3:0] op, input logic w, input logic [63:0] a, input logic [63:0] b, input logic [63:0] e, input int lat);
      int k = 0;
      send(op, w, a, b, 5'd1, 64'h2000);
      do begin
         @(negedge clk);
         k++;
      end while (!out_valid && k < 200);
      chk({nm, "_lat"}, 64'(k), 64'(lat));
      chk(nm, out_result, e);
   endtask

   initial begin
      int c0, seen;
      chk("pin_divw", model(4'd11, 1'b1, 64'h8000_0000, -64'd1), 64'hFFFF_FFFF_8000_0000);
      chk("pin_sraw", model(4'd7, 1'b1, 64'h8000_0000, 64'd4), 64'hFFFF_FFFF_F800_0000);
      chk("pin_remu0", model(4'd14, 1'b0, 64'd9, 64'd0), 64'd9);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 0); chk("rst_busy", busy, 0); chk("rst_ready", in_ready, 0);
      chk("rst_result", out_result, 0); chk("rst_pc", out_pc, 0); chk("rst_dst", out_dst, 0);
      reset = 1'b0;
      send(4'd0, 1'b0, 64'd5, 64'd7, 5'd3, 64'h100);
      @(negedge clk);
      chk("t1_valid", out_valid, 1); chk("t1_result", out_result, 64'd12);
      chk("t1_dst", out_dst, 64'd3); chk("t1_pc", out_pc, 64'h100);
      lit("addw", 4'd0, 1'b1, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 1);
      lit("sra", 4'd7, 1'b0, -64'd16, 64'd2, -64'd4, 1);
      lit("sltu", 4'd9, 1'b0, 64'd1, -64'd1, 64'd1, 1);
      lit("mul", 4'd10, 1'b0, 64'd3, -64'd4, 64'hFFFF_FFFF_FFFF_FFF4, 65);
      lit("mulw", 4'd10, 1'b1, 64'd3, -64'd4, 64'hFFFF_FFFF_FFFF_FFF4, 33);
      lit("div0", 4'd11, 1'b0, 64'd7, 64'd0, '1, 65);
      lit("rem0", 4'd13, 1'b0, 64'd7, 64'd0, 64'd7, 65);
      lit("divovf", 4'd11, 1'b0, 64'h8000_0000_0000_0000, -64'd1, 64'h8000_0000_0000_0000, 65);
      lit("removf", 4'd13, 1'b0, 64'h8000_0000_0000_0000, -64'd1, 64'd0, 65);
      lit("divneg", 4'd11, 1'b0, -64'd7, 64'd2, -64'd3, 65);
      lit("remneg", 4'd13, 1'b0, -64'd7, 64'd2, -64'd1, 65);
      // Backpressure: first result held, second op waits, both delivered once
      send(4'd0, 1'b0, 64'd10, 64'd20, 5'd4, 64'h300);
      out_ready = 1'b0;
      in_valid = 1'b1; in_op = 4'd0; in_word = 1'b0; in_srca = 64'd1; in_srcb = 64'd1; in_dst = 5'd5; in_pc = 64'h304;
      repeat (4) begin
         @(negedge clk);
         chk("bp_hold", out_result, 64'd30); chk("bp_ready", in_ready, 0); chk("bp_valid", out_valid, 1);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      c0 = n_cons;
      @(negedge clk);
      chk("bp_release", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_second", out_result, 64'd2); chk("bp_second_dst", out_dst, 64'd5);
      @(negedge clk); #1;
      chk("bp_count", 64'(n_cons - c0), 64'd2);
      // Flush during a divide
      send(4'd11, 1'b0, 64'd100, 64'd7, 5'd6, 64'h400);
      repeat (19) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("fl_busy", busy, 0); chk("fl_ready", in_ready, 1); chk("fl_valid", out_valid, 0);
      seen = 0;
      repeat (80) begin @(negedge clk); if (out_valid) seen++; end
      chk("fl_none", 64'(seen), 64'd0);
      // Asynchronous reset during a multiply
      send(4'd10, 1'b0, 64'd5, 64'd6, 5'd7, 64'h500);
      repeat (10) begin @(posedge clk); #1; end
      reset = 1'b1;
      #1;
      chk("ar_valid", out_valid, 0); chk("ar_busy", busy, 0); chk("ar_result", out_result, 0); chk("ar_ready", in_ready, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      seen = 0;
      repeat (80) begin @(negedge clk); if (out_valid) seen++; end
      chk("ar_none", 64'(seen), 64'd0);
      for (int i = 0; i < 24; i++) send(tv[i].op, tv[i].w, tv[i].a, tv[i].b, 5'(i), 64'h1000 + 64'(4 * i));
      repeat (70) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end
endmodule
